// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch types, widths and defaults (PC_BOUND_CHECK_EN consumer: fetch_controller)
package cpu_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] RESET_PC_DEF   = 16'h0000;
  localparam logic [WORD_W-1:0] HALT_INSTR_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // Saturating increment: stops at all-ones instead of wrapping.
  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (v == {WORD_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_controller_if_id_reg.sv
// rtl/fetch_controller_if_id_reg.sv - IF/ID valid/ready pipeline register with flush
module if_id_reg
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pc_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pc_o
);

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_q, pc_d;

  // Flush beats load, load beats drain; a word leaves only when the consumer takes it.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Stage storage; an in-flight word is dropped on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction-fetch sequencer; optional PC bound check via PC_BOUND_CHECK_EN
module fetch_controller
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] HALT_INSTR = HALT_INSTR_DEF,
  parameter int                MEM_DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [WORD_W-1:0] imem_addr_o,
  input  logic [WORD_W-1:0] imem_instr_i,
  input  logic              branch_valid_i,
  input  logic [WORD_W-1:0] branch_target_i,
  input  logic              id_ready_i,
  output logic              if_valid_o,
  output logic [WORD_W-1:0] if_instr_o,
  output logic [WORD_W-1:0] if_pc_o,
  output logic              halted_o,
  output logic              fault_o,
  output logic [WORD_W-1:0] fetch_count_o
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] count_q, count_d;

  logic branch_take;
  logic slot_free;
  logic pc_oob;
  logic is_halt;
  logic load_en;
  logic fault_trip;
  logic accept;

  // A branch is honoured everywhere except FAULT, which is sticky until reset.
  assign branch_take = branch_valid_i && (state_q != ST_FAULT);
  assign slot_free   = !if_valid_o || id_ready_i;
  assign is_halt     = (imem_instr_i == HALT_INSTR);

`ifdef PC_BOUND_CHECK_EN
  assign pc_oob = ({1'b0, pc_q} >= 17'(MEM_DEPTH));
`else
  localparam int unused_mem_depth = MEM_DEPTH;
  assign pc_oob = 1'b0;
`endif

  assign load_en    = (state_q == ST_FETCH) && slot_free && !branch_take && !pc_oob;
  assign fault_trip = (state_q == ST_FETCH) && slot_free && !branch_take && pc_oob;
  // The word being flushed by a branch is never credited as accepted.
  assign accept     = if_valid_o && id_ready_i && !branch_take;

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: branch first, then bound fault, then halt detection on a load.
  always_comb begin
    state_d = state_q;
    if (branch_take) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_FETCH;
        ST_FETCH: begin
          if (fault_trip) begin
            state_d = ST_FAULT;
          end else if (load_en && is_halt) begin
            state_d = ST_HALT;
          end
        end
        ST_HALT:  state_d = ST_HALT;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs and datapath next values; the PC parks on a halt word.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    if (branch_take) begin
      pc_d = branch_target_i;
    end else if (load_en && !is_halt) begin
      pc_d = pc_q + 1'b1;
    end
    if (accept) begin
      count_d = sat_inc(count_q);
    end
    halted_o = (state_q == ST_HALT);
`ifdef PC_BOUND_CHECK_EN
    fault_o  = (state_q == ST_FAULT);
`else
    fault_o  = 1'b0;
`endif
  end

  // Program counter and accepted-instruction counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign fetch_count_o = count_q;

  if_id_reg u_if_id (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (branch_take),
    .load_i  (load_en),
    .ready_i (id_ready_i),
    .instr_i (imem_instr_i),
    .pc_i    (pc_q),
    .valid_o (if_valid_o),
    .instr_o (if_instr_o),
    .pc_o    (if_pc_o)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller (PC_BOUND_CHECK_EN aware)
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        id_ready;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_count;

  logic [15:0] mem [256];

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:0]];

  fetch_controller #(
    .RESET_PC   (16'h0000),
    .HALT_INSTR (16'hFFFF),
    .MEM_DEPTH  (256)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .imem_addr_o     (imem_addr),
    .imem_instr_i    (imem_instr),
    .branch_valid_i  (branch_valid),
    .branch_target_i (branch_target),
    .id_ready_i      (id_ready),
    .if_valid_o      (if_valid),
    .if_instr_o      (if_instr),
    .if_pc_o         (if_pc),
    .halted_o        (halted),
    .fault_o         (fault),
    .fetch_count_o   (fetch_count)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem[pc[7:0]];
    exp_q.push_back(e);
  endtask

  task automatic reset_and_release();
    rst = 1'b1;
    branch_valid = 1'b0;
    branch_target = 16'h0000;
    id_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Monitor: every accepted word is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && if_valid && id_ready && !branch_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pc", if_pc, 16'hxxxx);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e.pc);
        check("sb_instr", if_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);

    // Reset state and streaming of words 0..7
    rst = 1'b1; branch_valid = 1'b0; branch_target = 16'h0; id_ready = 1'b1;
    repeat (2) tick();
    check("rst_if_valid", {15'd0, if_valid}, 16'd0);
    check("rst_if_instr", if_instr, 16'h0000);
    check("rst_if_pc", if_pc, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_fault", {15'd0, fault}, 16'd0);
    check("rst_count", fetch_count, 16'd0);
    check("rst_addr", imem_addr, 16'h0000);
    for (int i = 0; i < 8; i++) push(16'(i));
    rst = 1'b0;
    tick();
    check("idle_no_valid", {15'd0, if_valid}, 16'd0);
    tick();
    check("first_valid", {15'd0, if_valid}, 16'd1);
    check("first_pc", if_pc, 16'h0000);
    check("first_addr", imem_addr, 16'h0001);
    repeat (8) tick();
    id_ready = 1'b0;
    check("stream_count", fetch_count, 16'd8);

    // Stall for 3 cycles while word 3 is held
    for (int i = 0; i < 4; i++) push(16'(i));
    reset_and_release();
    repeat (5) tick();
    id_ready = 1'b0;
    check("stall_pc_start", if_pc, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", if_pc, 16'h0003);
      check("stall_instr", if_instr, 16'hA003);
      check("stall_addr", imem_addr, 16'h0004);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("resume_pc", if_pc, 16'h0004);
    check("resume_count", fetch_count, 16'd4);

    // Branch to 0x0040 while word 5 is presented
    for (int i = 0; i < 5; i++) push(16'(i));
    push(16'h0040);
    reset_and_release();
    repeat (7) tick();
    check("br_pc5", if_pc, 16'h0005);
    branch_valid = 1'b1; branch_target = 16'h0040;
    tick();
    branch_valid = 1'b0;
    check("br_flush", {15'd0, if_valid}, 16'd0);
    check("br_addr", imem_addr, 16'h0040);
    tick();
    check("br_target_pc", if_pc, 16'h0040);
    tick();
    id_ready = 1'b0;
    check("br_count", fetch_count, 16'd6);

    // Halt on word 6, then restart by branch to 0
    mem[6] = 16'hFFFF;
    for (int i = 0; i < 7; i++) push(16'(i));
    reset_and_release();
    repeat (8) tick();
    check("halt_flag", {15'd0, halted}, 16'd1);
    check("halt_valid", {15'd0, if_valid}, 16'd1);
    check("halt_instr", if_instr, 16'hFFFF);
    check("halt_addr", imem_addr, 16'h0006);
    tick();
    check("halt_drained", {15'd0, if_valid}, 16'd0);
    check("halt_addr_hold", imem_addr, 16'h0006);
    tick();
    check("halt_stays", {15'd0, halted}, 16'd1);
    check("halt_no_load", {15'd0, if_valid}, 16'd0);
    branch_valid = 1'b1; branch_target = 16'h0000;
    tick();
    branch_valid = 1'b0;
    check("unhalt_flag", {15'd0, halted}, 16'd0);
    check("unhalt_addr", imem_addr, 16'h0000);
    tick();
    id_ready = 1'b0;
    check("unhalt_valid", {15'd0, if_valid}, 16'd1);
    check("unhalt_pc", if_pc, 16'h0000);
    check("halt_count", fetch_count, 16'd7);
    mem[6] = 16'hA006;

    // Asynchronous reset in the middle of the stream
    for (int i = 0; i < 3; i++) push(16'(i));
    reset_and_release();
    repeat (5) tick();
    check("arst_pre_pc", if_pc, 16'h0003);
    check("arst_pre_count", fetch_count, 16'd3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {15'd0, if_valid}, 16'd0);
    check("arst_count", fetch_count, 16'd0);
    check("arst_if_pc", if_pc, 16'h0000);
    check("arst_addr", imem_addr, 16'h0000);

    // Crossing the MEM_DEPTH boundary at 0x0100
    push(16'h00FE);
    push(16'h00FF);
    reset_and_release();
    tick();
    branch_valid = 1'b1; branch_target = 16'h00FE;
    tick();
    branch_valid = 1'b0;
    check("bnd_addr", imem_addr, 16'h00FE);
    repeat (3) tick();
`ifdef PC_BOUND_CHECK_EN
    check("bnd_fault", {15'd0, fault}, 16'd1);
    check("bnd_drained", {15'd0, if_valid}, 16'd0);
    branch_valid = 1'b1; branch_target = 16'h0000;
    tick();
    branch_valid = 1'b0;
    check("bnd_sticky", {15'd0, fault}, 16'd1);
    check("bnd_br_ignored", imem_addr, 16'h0100);
    tick();
    check("bnd_no_load", {15'd0, if_valid}, 16'd0);
`else
    id_ready = 1'b0;
    check("bnd_nofault", {15'd0, fault}, 16'd0);
    check("bnd_valid", {15'd0, if_valid}, 16'd1);
    check("bnd_pc", if_pc, 16'h0100);
`endif
    tick();

    check("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
